// File: rtl/ycbcr_pkg.sv
// Shared constants and helpers for the 8-lane YCbCr->RGB converter.
// Coefficients are full-range BT.601 values scaled by 2^FRAC_BITS.
package ycbcr_pkg;

   localparam int LANES     = 8;
   localparam int FRAC_BITS = 8;
   localparam int C_R_CR    = 359;
   localparam int C_G_CB    = 88;
   localparam int C_G_CR    = 183;
   localparam int C_B_CB    = 454;
   localparam int OFFSET    = 128;

   // Saturates a signed 11-bit channel sum into an 8-bit pixel value.
   function automatic logic [7:0] clamp8(input logic signed [10:0] v);
      if (v[10])
         return 8'd0;
      else if (v > 11'sd255)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/ycbcr2rgb_lane.sv
// One pixel's three-stage YCbCr->RGB datapath; every register advances only when en is high.
// S1 removes the chroma offset, S2 forms the products, S3 rounds, adds Y and clamps.
module ycbcr2rgb_lane
   import ycbcr_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  y,
   input  logic [7:0]  cb,
   input  logic [7:0]  cr,
   output logic [23:0] rgb
);

   localparam logic signed [17:0] K_R_CR = 18'(C_R_CR);
   localparam logic signed [17:0] K_G_CB = 18'(C_G_CB);
   localparam logic signed [17:0] K_G_CR = 18'(C_G_CR);
   localparam logic signed [17:0] K_B_CB = 18'(C_B_CB);
   localparam logic signed [17:0] RND    = 18'(1 << (FRAC_BITS - 1));
   localparam logic signed [8:0]  OFS    = 9'(OFFSET);

   logic [7:0]         y_s1_reg, y_s2_reg;
   logic signed [8:0]  cb_s1_reg, cr_s1_reg;
   logic signed [17:0] pr_reg, pg_reg, pb_reg;
   logic signed [17:0] cb_ext, cr_ext;
   logic [23:0]        rgb_reg;

   // Round, floor-shift (>>> rounds toward -inf), then add the unsigned luma.
   function automatic logic signed [10:0] channel(input logic [7:0] yv, input logic signed [17:0] p);
      logic signed [17:0] sh;
      sh = (p + RND) >>> FRAC_BITS;
      return signed'({3'b000, yv}) + signed'(sh[10:0]);
   endfunction

   assign cb_ext = {{9{cb_s1_reg[8]}}, cb_s1_reg};
   assign cr_ext = {{9{cr_s1_reg[8]}}, cr_s1_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_s1_reg  <= '0;
         cb_s1_reg <= '0;
         cr_s1_reg <= '0;
         y_s2_reg  <= '0;
         pr_reg    <= '0;
         pg_reg    <= '0;
         pb_reg    <= '0;
         rgb_reg   <= '0;
      end else if (en) begin
         y_s1_reg  <= y;
         cb_s1_reg <= signed'({1'b0, cb}) - OFS;
         cr_s1_reg <= signed'({1'b0, cr}) - OFS;
         y_s2_reg  <= y_s1_reg;
         pr_reg    <= K_R_CR * cr_ext;
         pg_reg    <= -(K_G_CB * cb_ext) - (K_G_CR * cr_ext);
         pb_reg    <= K_B_CB * cb_ext;
         rgb_reg   <= {clamp8(channel(y_s2_reg, pr_reg)),
                       clamp8(channel(y_s2_reg, pg_reg)),
                       clamp8(channel(y_s2_reg, pb_reg))};
      end
   end

   assign rgb = rgb_reg;

endmodule

// File: rtl/ycbcr2rgb.sv
// 8-lane full-range BT.601 YCbCr->RGB converter with valid/ready on both sides.
// Holds only the valid chain and the global advance enable; lanes carry the arithmetic.
module ycbcr2rgb
   import ycbcr_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_luma_data1, i_luma_data2, i_luma_data3, i_luma_data4,
   input  logic [7:0]  i_luma_data5, i_luma_data6, i_luma_data7, i_luma_data8,
   input  logic [7:0]  i_cb_data1, i_cb_data2, i_cb_data3, i_cb_data4,
   input  logic [7:0]  i_cb_data5, i_cb_data6, i_cb_data7, i_cb_data8,
   input  logic [7:0]  i_cr_data1, i_cr_data2, i_cr_data3, i_cr_data4,
   input  logic [7:0]  i_cr_data5, i_cr_data6, i_cr_data7, i_cr_data8,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [23:0] o_rgb_data1, o_rgb_data2, o_rgb_data3, o_rgb_data4,
   output logic [23:0] o_rgb_data5, o_rgb_data6, o_rgb_data7, o_rgb_data8,
   output logic        o_valid,
   input  logic        i_ready
);

   logic [7:0]  luma [LANES];
   logic [7:0]  cb   [LANES];
   logic [7:0]  cr   [LANES];
   logic [23:0] rgb  [LANES];
   logic [2:0]  valid_reg;
   logic        en;

   assign luma = '{i_luma_data1, i_luma_data2, i_luma_data3, i_luma_data4,
                   i_luma_data5, i_luma_data6, i_luma_data7, i_luma_data8};
   assign cb   = '{i_cb_data1, i_cb_data2, i_cb_data3, i_cb_data4,
                   i_cb_data5, i_cb_data6, i_cb_data7, i_cb_data8};
   assign cr   = '{i_cr_data1, i_cr_data2, i_cr_data3, i_cr_data4,
                   i_cr_data5, i_cr_data6, i_cr_data7, i_cr_data8};

   assign o_rgb_data1 = rgb[0];
   assign o_rgb_data2 = rgb[1];
   assign o_rgb_data3 = rgb[2];
   assign o_rgb_data4 = rgb[3];
   assign o_rgb_data5 = rgb[4];
   assign o_rgb_data6 = rgb[5];
   assign o_rgb_data7 = rgb[6];
   assign o_rgb_data8 = rgb[7];

   // The whole pipe freezes only when the output stage is full and not taken.
   assign en      = ~(valid_reg[2] & ~i_ready);
   assign o_ready = en;
   assign o_valid = valid_reg[2];

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         valid_reg <= '0;
      else if (en)
         valid_reg <= {valid_reg[1:0], i_valid};
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         ycbcr2rgb_lane u_lane (
            .clk   (i_clk),
            .rst_n (i_rst),
            .en    (en),
            .y     (luma[gi]),
            .cb    (cb[gi]),
            .cr    (cr[gi]),
            .rgb   (rgb[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: the driver queues expected beats, a negedge monitor pops and compares.
module tb_ycbcr2rgb;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic        o_ready, o_valid;
   logic [7:0]  y_d  [8];
   logic [7:0]  cb_d [8];
   logic [7:0]  cr_d [8];
   logic [23:0] rgb  [8];

   int checks = 0;
   int failures = 0;
   logic [191:0] sb [$];

   always #5 i_clk = ~i_clk;

   ycbcr2rgb dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_luma_data1(y_d[0]), .i_luma_data2(y_d[1]), .i_luma_data3(y_d[2]), .i_luma_data4(y_d[3]),
      .i_luma_data5(y_d[4]), .i_luma_data6(y_d[5]), .i_luma_data7(y_d[6]), .i_luma_data8(y_d[7]),
      .i_cb_data1(cb_d[0]), .i_cb_data2(cb_d[1]), .i_cb_data3(cb_d[2]), .i_cb_data4(cb_d[3]),
      .i_cb_data5(cb_d[4]), .i_cb_data6(cb_d[5]), .i_cb_data7(cb_d[6]), .i_cb_data8(cb_d[7]),
      .i_cr_data1(cr_d[0]), .i_cr_data2(cr_d[1]), .i_cr_data3(cr_d[2]), .i_cr_data4(cr_d[3]),
      .i_cr_data5(cr_d[4]), .i_cr_data6(cr_d[5]), .i_cr_data7(cr_d[6]), .i_cr_data8(cr_d[7]),
      .i_valid(i_valid), .o_ready(o_ready),
      .o_rgb_data1(rgb[0]), .o_rgb_data2(rgb[1]), .o_rgb_data3(rgb[2]), .o_rgb_data4(rgb[3]),
      .o_rgb_data5(rgb[4]), .o_rgb_data6(rgb[5]), .o_rgb_data7(rgb[6]), .o_rgb_data8(rgb[7]),
      .o_valid(o_valid), .i_ready(i_ready)
   );

   function automatic logic [7:0] cl(input int v);
      if (v < 0) return 8'd0;
      if (v > 255) return 8'hFF;
      return 8'(v);
   endfunction

   function automatic logic [23:0] px(input int y, input int cb, input int cr);
      int r, g, b;
      r = y + ((359 * (cr - 128) + 128) >>> 8);
      g = y + ((-88 * (cb - 128) - 183 * (cr - 128) + 128) >>> 8);
      b = y + ((454 * (cb - 128) + 128) >>> 8);
      return {cl(r), cl(g), cl(b)};
   endfunction

   function automatic logic [191:0] model(input logic [63:0] y, input logic [63:0] cb, input logic [63:0] cr);
      logic [191:0] e;
      for (int i = 0; i < 8; i++)
         e[24*i +: 24] = px(int'(y[8*i +: 8]), int'(cb[8*i +: 8]), int'(cr[8*i +: 8]));
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Presents a beat from posedge+1 and holds it until o_ready is seen at a negedge.
   task automatic send(input logic [63:0] y, input logic [63:0] cb, input logic [63:0] cr,
                       input logic [191:0] e, input bit push);
      int n = 0;
      for (int i = 0; i < 8; i++) begin
         y_d[i]  = y[8*i +: 8];
         cb_d[i] = cb[8*i +: 8];
         cr_d[i] = cr[8*i +: 8];
      end
      i_valid = 1'b1;
      forever begin
         @(negedge i_clk);
         if (o_ready) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
         @(posedge i_clk); #1;
      end
      if (push) sb.push_back(e);
      $display("beat sent y=%h cb=%h cr=%h", y, cb, cr);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic check_latency(input string nm);
      chk({nm, "_lat_c1"}, 32'(o_valid), 32'd0);
      @(posedge i_clk); #1;
      chk({nm, "_lat_c2"}, 32'(o_valid), 32'd0);
      @(posedge i_clk); #1;
      chk({nm, "_lat_c3"}, 32'(o_valid), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   // Monitor: one comparison per lane for each beat the DUT hands over.
   initial begin
      logic [191:0] e;
      forever begin
         @(negedge i_clk);
         if (i_rst && o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat actual=%h required=no beat", rgb[0]);
            end else begin
               e = sb.pop_front();
               for (int i = 0; i < 8; i++) begin
                  if (i > 0) checks++;
                  if (rgb[i] !== e[24*i +: 24]) begin
                     failures++;
                     $display("FAIL lane%0d_rgb actual=%h required=%h", i + 1, rgb[i], e[24*i +: 24]);
                  end
               end
               $display("beat out lane1=%h lane8=%h", rgb[0], rgb[7]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]  y, cb, cr;
      logic [191:0] e;
      logic [23:0]  snap [8];
      int           n;
      bit           pat [8];
      for (int i = 0; i < 8; i++) begin y_d[i] = 0; cb_d[i] = 0; cr_d[i] = 0; end

      // Reset state
      #2 i_rst = 1'b0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_rgb1", 32'(rgb[0]), 32'd0);
      chk("rst_rgb8", 32'(rgb[7]), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b1;
      idle(2);

      // Mid-grey on all lanes, plus latency
      send({8{8'd128}}, {8{8'd128}}, {8{8'd128}}, {8{24'h808080}}, 1'b1);
      check_latency("t1");
      chk("t1_rgb1", 32'(rgb[0]), 32'h808080);
      idle(3);

      // Clamp corners
      send({8{8'd255}}, {8{8'd128}}, {8{8'd255}}, {8{24'hFFA4FF}}, 1'b1);
      send({8{8'd0}},   {8{8'd0}},   {8{8'd0}},   {8{24'h008800}}, 1'b1);
      idle(5);

      // Distinct values per lane
      y  = {8'd16, 8'd235, 8'd100, 8'd50, 8'd200, 8'd0, 8'd255, 8'd90};
      cb = {8'd240, 8'd16, 8'd128, 8'd90, 8'd30, 8'd255, 8'd1, 8'd170};
      cr = {8'd16, 8'd240, 8'd200, 8'd128, 8'd60, 8'd10, 8'd250, 8'd77};
      send(y, cb, cr, model(y, cb, cr), 1'b1);
      send(cr, y, cb, model(cr, y, cb), 1'b1);
      idle(5);

      // Streaming with a 5-cycle downstream stall
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               y  = {$urandom, $urandom};
               cb = {$urandom, $urandom};
               cr = {$urandom, $urandom};
               send(y, cb, cr, model(y, cb, cr), 1'b1);
            end
         end
         begin
            n = 0;
            while (!o_valid && n < 50) begin @(posedge i_clk); #1; n++; end
            chk("t4_saw_valid", 32'(o_valid), 32'd1);
            idle(1);
            i_ready = 1'b0;
            for (int i = 0; i < 8; i++) snap[i] = rgb[i];
            for (int c = 0; c < 5; c++) begin
               @(negedge i_clk);
               chk("t4_stall_ready", 32'(o_ready), 32'd0);
               chk("t4_stall_valid", 32'(o_valid), 32'd1);
               for (int i = 0; i < 8; i++) chk("t4_hold", 32'(rgb[i]), 32'(snap[i]));
               @(posedge i_clk); #1;
            end
            i_ready = 1'b1;
         end
      join
      idle(6);
      chk("t4_drained", 32'(sb.size()), 32'd0);

      // Bubbles: o_valid repeats the i_valid pattern three cycles later
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int j = 0; j < 12; j++) begin
         chk($sformatf("t5_ovalid_%0d", j), 32'(o_valid), (j >= 3 && j < 11) ? 32'(pat[j-3]) : 32'd0);
         if (j < 8) begin
            y  = {$urandom, $urandom};
            cb = {$urandom, $urandom};
            cr = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) begin
               y_d[i] = y[8*i +: 8]; cb_d[i] = cb[8*i +: 8]; cr_d[i] = cr[8*i +: 8];
            end
            i_valid = pat[j];
            if (pat[j]) sb.push_back(model(y, cb, cr));
         end else begin
            i_valid = 1'b0;
         end
         @(posedge i_clk); #1;
      end
      idle(3);

      // Reset with three beats parked in the pipe
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         y = {8{8'(k * 40)}};
         send(y, y, y, '0, 1'b0);
      end
      chk("t6_full", 32'(o_valid), 32'd1);
      #2 i_rst = 1'b0;
      #1;
      chk("t6_async_valid", 32'(o_valid), 32'd0);
      chk("t6_async_rgb1", 32'(rgb[0]), 32'd0);
      chk("t6_async_rgb5", 32'(rgb[4]), 32'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      i_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("t6_no_ghost", 32'(o_valid), 32'd0);
         @(posedge i_clk); #1;
      end
      y  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      cb = {8'd200, 8'd150, 8'd100, 8'd50, 8'd0, 8'd255, 8'd128, 8'd127};
      cr = {8'd129, 8'd127, 8'd64, 8'd192, 8'd255, 8'd0, 8'd128, 8'd33};
      send(y, cb, cr, model(y, cb, cr), 1'b1);
      check_latency("t6");
      idle(5);
      chk("final_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
